ecc_scrub_ctrl: RTL and testbench

- Background memory scrubber that sits downstream of the read-side SECDED decoder (DW_ecc, gen=0) and upstream of the write-side encoder (DW_ecc, gen=1).
- Walks a configured address window and reads each word. When the decoder reports a single-bit error, it writes the corrected word back through the encoder path.
- Counts corrected and uncorrectable errors, and logs the address and syndrome of the most recent error.

---
 rtl/ecc_scrub_pkg.sv | 25 ++
 rtl/ecc_sat_counter.sv | 19 +
 rtl/ecc_scrub_ctrl.sv | 122 ++++++++++++
 tb/tb_ecc_scrub_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_scrub_pkg.sv
// Shared types for the ECC scrubber: FSM state encoding and error classification.
package ecc_scrub_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_RD_REQ,
    S_RD_WAIT,
    S_WR_REQ,
    S_NEXT
  } scrub_state_t;

  // Error class of one decoded read word
  localparam logic [1:0] ERR_NONE   = 2'd0;
  localparam logic [1:0] ERR_CORR   = 2'd1;
  localparam logic [1:0] ERR_UNCORR = 2'd2;

  // A multiple-bit flag only matters when the decoder flagged an error at all
  function automatic logic [1:0] err_class(input logic detect, input logic multpl);
    if (!detect)     return ERR_NONE;
    else if (multpl) return ERR_UNCORR;
    else             return ERR_CORR;
  endfunction

endpackage

// File: rtl/ecc_sat_counter.sv
// Saturating event counter; a clear wins over a coincident increment.
module ecc_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  // count up, hold at all-ones, clear has priority
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    cnt <= '0;
    else if (clr)               cnt <= '0;
    else if (inc && cnt != '1)  cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/ecc_scrub_ctrl.sv
// Background SECDED scrubber: walks [addr_lo, addr_hi], reads each word through
// the decoder and writes back corrected single-bit errors via the encoder path.
module ecc_scrub_ctrl
  import ecc_scrub_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int CHK_WIDTH  = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int CNT_WIDTH  = 16,
  parameter int IVL_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scrub_en,
  input  logic [IVL_WIDTH-1:0]  interval,
  input  logic [ADDR_WIDTH-1:0] addr_lo,
  input  logic [ADDR_WIDTH-1:0] addr_hi,
  input  logic                  clr_cnt,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] dec_data,
  input  logic                  dec_err_detect,
  input  logic                  dec_err_multpl,
  input  logic [CHK_WIDTH-1:0]  dec_syndrome,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  corr_cnt,
  output logic [CNT_WIDTH-1:0]  uncorr_cnt,
  output logic [ADDR_WIDTH-1:0] last_err_addr,
  output logic [CHK_WIDTH-1:0]  last_syndrome,
  output logic                  err_irq,
  output logic                  pass_done
);

  scrub_state_t          state, next_state;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [IVL_WIDTH-1:0]  ivl_cnt;
  logic [1:0]            ecls;
  logic                  rd_done, corr_inc, uncorr_inc, wrap;

  assign ecls       = err_class(dec_err_detect, dec_err_multpl);
  assign rd_done    = (state == S_RD_WAIT) && mem_rvalid;
  assign corr_inc   = rd_done && (ecls == ERR_CORR);
  assign uncorr_inc = rd_done && (ecls == ERR_UNCORR);
  // >= rather than == so an inverted window collapses onto addr_lo
  assign wrap       = (cur_addr >= addr_hi);
  assign mem_addr   = cur_addr;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // next-state logic; scrub_en only takes effect in IDLE, WAIT and NEXT
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:    if (scrub_en) next_state = S_WAIT;
      S_WAIT:    if (!scrub_en)          next_state = S_IDLE;
                 else if (ivl_cnt == '0) next_state = S_RD_REQ;
      S_RD_REQ:  if (mem_gnt) next_state = S_RD_WAIT;
      S_RD_WAIT: if (mem_rvalid) next_state = (ecls == ERR_CORR) ? S_WR_REQ : S_NEXT;
      S_WR_REQ:  if (mem_gnt) next_state = S_NEXT;
      S_NEXT:    next_state = scrub_en ? S_WAIT : S_IDLE;
      default:   next_state = S_IDLE;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    mem_req = (state == S_RD_REQ) || (state == S_WR_REQ);
    busy    = (state != S_IDLE);
  end

  // address walk, interval timer, write data, error log and pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_addr      <= '0;
      ivl_cnt       <= '0;
      mem_we        <= 1'b0;
      mem_wdata     <= '0;
      last_err_addr <= '0;
      last_syndrome <= '0;
      err_irq       <= 1'b0;
      pass_done     <= 1'b0;
    end else begin
      err_irq   <= rd_done && (ecls != ERR_NONE);
      pass_done <= (state == S_NEXT) && wrap;
      mem_we    <= (next_state == S_WR_REQ);
      if (corr_inc) mem_wdata <= dec_data;
      if (rd_done && (ecls != ERR_NONE)) begin
        last_err_addr <= cur_addr;
        last_syndrome <= dec_syndrome;
      end
      case (state)
        S_IDLE: if (scrub_en) begin
          cur_addr <= addr_lo;
          ivl_cnt  <= interval;
        end
        S_WAIT: if (scrub_en && ivl_cnt != '0) ivl_cnt <= ivl_cnt - 1'b1;
        S_NEXT: begin
          cur_addr <= wrap ? addr_lo : cur_addr + 1'b1;
          ivl_cnt  <= interval;
        end
        default: ;
      endcase
    end
  end

  ecc_sat_counter #(.W(CNT_WIDTH)) u_corr_cnt (
    .clk(clk), .rst(rst), .inc(corr_inc), .clr(clr_cnt), .cnt(corr_cnt)
  );

  ecc_sat_counter #(.W(CNT_WIDTH)) u_uncorr_cnt (
    .clk(clk), .rst(rst), .inc(uncorr_inc), .clr(clr_cnt), .cnt(uncorr_cnt)
  );

endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// Directed bench for ecc_scrub_ctrl: a memory/decoder responder with
// programmable grant and read latency plus per-address error injection.
module tb_ecc_scrub_ctrl;

  localparam int DW = 64, CW = 8, AW = 10, NW = 16, IW = 16;
  localparam logic [DW-1:0] CORR_DATA = 64'hDEAD_BEEF_0000_0001;

  logic          clk = 1'b0;
  logic          rst, scrub_en, clr_cnt, mem_gnt, mem_rvalid;
  logic          dec_err_detect, dec_err_multpl;
  logic [IW-1:0] interval;
  logic [AW-1:0] addr_lo, addr_hi;
  logic [DW-1:0] dec_data;
  logic [CW-1:0] dec_syndrome;

  logic          mem_req, mem_we, busy, err_irq, pass_done;
  logic [AW-1:0] mem_addr, last_err_addr;
  logic [DW-1:0] mem_wdata;
  logic [NW-1:0] corr_cnt, uncorr_cnt;
  logic [CW-1:0] last_syndrome;

  // narrow-counter twin, driven in lockstep with the main instance
  logic          n_req, n_we, n_busy, n_irq, n_pass;
  logic [AW-1:0] n_addr, n_lea;
  logic [DW-1:0] n_wdata;
  logic [1:0]    corr_cnt2, uncorr_cnt2;
  logic [CW-1:0] n_syn;

  ecc_scrub_ctrl #(.DATA_WIDTH(DW), .CHK_WIDTH(CW), .ADDR_WIDTH(AW), .CNT_WIDTH(NW), .IVL_WIDTH(IW)) dut (
    .clk(clk), .rst(rst), .scrub_en(scrub_en), .interval(interval), .addr_lo(addr_lo), .addr_hi(addr_hi),
    .clr_cnt(clr_cnt), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .dec_data(dec_data), .dec_err_detect(dec_err_detect),
    .dec_err_multpl(dec_err_multpl), .dec_syndrome(dec_syndrome), .busy(busy), .corr_cnt(corr_cnt),
    .uncorr_cnt(uncorr_cnt), .last_err_addr(last_err_addr), .last_syndrome(last_syndrome),
    .err_irq(err_irq), .pass_done(pass_done)
  );

  ecc_scrub_ctrl #(.DATA_WIDTH(DW), .CHK_WIDTH(CW), .ADDR_WIDTH(AW), .CNT_WIDTH(2), .IVL_WIDTH(IW)) dut2 (
    .clk(clk), .rst(rst), .scrub_en(scrub_en), .interval(interval), .addr_lo(addr_lo), .addr_hi(addr_hi),
    .clr_cnt(clr_cnt), .mem_req(n_req), .mem_we(n_we), .mem_addr(n_addr), .mem_wdata(n_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .dec_data(dec_data), .dec_err_detect(dec_err_detect),
    .dec_err_multpl(dec_err_multpl), .dec_syndrome(dec_syndrome), .busy(n_busy), .corr_cnt(corr_cnt2),
    .uncorr_cnt(uncorr_cnt2), .last_err_addr(n_lea), .last_syndrome(n_syn),
    .err_irq(n_irq), .pass_done(n_pass)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  int gnt_dly = 0, rv_dly = 1, c_addr = -1, u_addr = -1;
  bit corr_all = 0, clr_once = 0;
  int cyc = 0, req_age = 0, rv_cnt = 0, irq_cnt = 0, pass_cnt = 0, stab_err = 0;
  bit pend = 0;
  logic [AW-1:0] pend_addr, hold_addr;
  logic          hold_we;
  logic [DW-1:0] hold_data;
  int            rd_q[$], wr_q[$], rd_cyc[$];
  logic [DW-1:0] wd_q[$];

  // memory + decoder responder and transaction monitor (mid-cycle, on negedge)
  initial begin
    mem_gnt = 0; mem_rvalid = 0; clr_cnt = 0;
    dec_err_detect = 0; dec_err_multpl = 0; dec_data = '0; dec_syndrome = '0;
    forever begin
      @(negedge clk);
      cyc++;
      mem_gnt = 0; mem_rvalid = 0; clr_cnt = 0;
      dec_err_detect = 0; dec_err_multpl = 0;
      if (rst) begin
        pend = 0; req_age = 0; irq_cnt = 0; pass_cnt = 0; stab_err = 0;
        rd_q.delete(); wr_q.delete(); wd_q.delete(); rd_cyc.delete();
      end else begin
        if (err_irq)   irq_cnt++;
        if (pass_done) pass_cnt++;
        if (pend) begin
          rv_cnt--;
          if (rv_cnt == 0) begin
            pend = 0; mem_rvalid = 1;
            if (corr_all || int'(pend_addr) == c_addr) begin
              dec_err_detect = 1; dec_err_multpl = 0; dec_data = CORR_DATA; dec_syndrome = 8'h3A;
            end else if (int'(pend_addr) == u_addr) begin
              dec_err_detect = 1; dec_err_multpl = 1; dec_data = 64'h0BAD_0BAD_0BAD_0BAD; dec_syndrome = 8'hC5;
            end else begin
              dec_data = {{(DW-AW){1'b0}}, pend_addr}; dec_syndrome = '0;
            end
            if (clr_once) begin clr_cnt = 1; clr_once = 0; end
          end
        end
        if (mem_req) begin
          if (req_age == 0) begin
            hold_addr = mem_addr; hold_we = mem_we; hold_data = mem_wdata;
          end else if (mem_addr !== hold_addr || mem_we !== hold_we || (mem_we && mem_wdata !== hold_data))
            stab_err++;
          if (req_age >= gnt_dly) begin
            mem_gnt = 1; req_age = 0;
            if (mem_we) begin
              wr_q.push_back(int'(mem_addr)); wd_q.push_back(mem_wdata);
            end else begin
              rd_q.push_back(int'(mem_addr)); rd_cyc.push_back(cyc);
              pend = 1; rv_cnt = rv_dly; pend_addr = mem_addr;
            end
          end else req_age++;
        end else req_age = 0;
      end
    end
  end

  task automatic do_reset();
    rst = 1; scrub_en = 0;
    gnt_dly = 0; rv_dly = 1; c_addr = -1; u_addr = -1; corr_all = 0; clr_once = 0;
    interval = '0; addr_lo = 10'd4; addr_hi = 10'd7;
    repeat (2) @(negedge clk);
    #1 rst = 0;
  endtask

  task automatic wait_rd(input int n);
    int i;
    for (i = 0; i < 400 && rd_q.size() < n; i++) begin @(negedge clk); #1; end
    n_cmp++; if (rd_q.size() < n) begin n_err++; $display("FAIL wait_rd timeout: got %0d reads want %0d", rd_q.size(), n); end
  endtask

  task automatic wait_wr(input int n);
    int i;
    for (i = 0; i < 400 && wr_q.size() < n; i++) begin @(negedge clk); #1; end
    n_cmp++; if (wr_q.size() < n) begin n_err++; $display("FAIL wait_wr timeout: got %0d writes want %0d", wr_q.size(), n); end
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 400 && busy !== 1'b0; i++) begin @(negedge clk); #1; end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL wait_idle timeout: busy=%b want 0", busy); end
  endtask

  task automatic test_reset();
    rst = 1; scrub_en = 0; interval = '0; addr_lo = '0; addr_hi = '0;
    repeat (2) @(negedge clk);
    n_cmp++; if ({mem_req, mem_we, busy, err_irq, pass_done} !== 5'b0) begin n_err++;
      $display("FAIL reset_ctl: got %b want 00000", {mem_req, mem_we, busy, err_irq, pass_done}); end
    n_cmp++; if (mem_addr !== '0 || mem_wdata !== '0) begin n_err++;
      $display("FAIL reset_mem: got addr=%0h wdata=%0h want 0", mem_addr, mem_wdata); end
    n_cmp++; if (corr_cnt !== '0 || uncorr_cnt !== '0 || last_err_addr !== '0 || last_syndrome !== '0) begin n_err++;
      $display("FAIL reset_stats: got %0d %0d %0h %0h want 0", corr_cnt, uncorr_cnt, last_err_addr, last_syndrome); end
  endtask

  task automatic test_clean_window();
    int exp_a[5] = '{4, 5, 6, 7, 4};
    do_reset();
    scrub_en = 1;
    wait_rd(5);
    scrub_en = 0;
    wait_idle();
    n_cmp++; if (rd_q.size() !== 5) begin n_err++; $display("FAIL clean_nrd: got %0d want 5", rd_q.size()); end
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (rd_q.size() > i && rd_q[i] !== exp_a[i]) begin n_err++; $display("FAIL clean_addr%0d: got %0d want %0d", i, rd_q[i], exp_a[i]); end
    end
    n_cmp++; if (pass_cnt !== 1) begin n_err++; $display("FAIL clean_pass: got %0d want 1", pass_cnt); end
    n_cmp++; if (wr_q.size() !== 0 || irq_cnt !== 0) begin n_err++; $display("FAIL clean_nowr: got wr=%0d irq=%0d want 0", wr_q.size(), irq_cnt); end
    n_cmp++; if (corr_cnt !== '0 || uncorr_cnt !== '0) begin n_err++; $display("FAIL clean_cnt: got %0d %0d want 0", corr_cnt, uncorr_cnt); end
    n_cmp++; if (rd_cyc.size() > 1 && rd_cyc[1] - rd_cyc[0] !== 4) begin n_err++; $display("FAIL clean_rate: got %0d want 4", rd_cyc[1] - rd_cyc[0]); end
  endtask

  task automatic test_single_bit();
    do_reset();
    c_addr = 5;
    scrub_en = 1;
    wait_rd(3);
    scrub_en = 0;
    wait_idle();
    n_cmp++; if (wr_q.size() !== 1) begin n_err++; $display("FAIL sb_nwr: got %0d want 1", wr_q.size()); end
    n_cmp++; if (wr_q.size() > 0 && wr_q[0] !== 5) begin n_err++; $display("FAIL sb_wr_addr: got %0d want 5", wr_q[0]); end
    n_cmp++; if (wd_q.size() > 0 && wd_q[0] !== CORR_DATA) begin n_err++; $display("FAIL sb_wr_data: got %0h want %0h", wd_q[0], CORR_DATA); end
    n_cmp++; if (rd_q.size() > 2 && rd_q[2] !== 6) begin n_err++; $display("FAIL sb_next_rd: got %0d want 6", rd_q[2]); end
    n_cmp++; if (corr_cnt !== 16'd1 || uncorr_cnt !== '0) begin n_err++; $display("FAIL sb_cnt: got %0d/%0d want 1/0", corr_cnt, uncorr_cnt); end
    n_cmp++; if (corr_cnt2 !== 2'd1) begin n_err++; $display("FAIL sb_cnt_narrow: got %0d want 1", corr_cnt2); end
    n_cmp++; if (last_err_addr !== 10'd5 || last_syndrome !== 8'h3A) begin n_err++; $display("FAIL sb_log: got %0d/%0h want 5/3a", last_err_addr, last_syndrome); end
    n_cmp++; if (irq_cnt !== 1) begin n_err++; $display("FAIL sb_irq: got %0d want 1", irq_cnt); end
  endtask

  task automatic test_double_bit();
    do_reset();
    u_addr = 6;
    scrub_en = 1;
    wait_rd(4);
    scrub_en = 0;
    wait_idle();
    n_cmp++; if (wr_q.size() !== 0) begin n_err++; $display("FAIL db_nwr: got %0d want 0", wr_q.size()); end
    n_cmp++; if (uncorr_cnt !== 16'd1 || corr_cnt !== '0) begin n_err++; $display("FAIL db_cnt: got %0d/%0d want 1/0", uncorr_cnt, corr_cnt); end
    n_cmp++; if (last_err_addr !== 10'd6 || last_syndrome !== 8'hC5) begin n_err++; $display("FAIL db_log: got %0d/%0h want 6/c5", last_err_addr, last_syndrome); end
    n_cmp++; if (irq_cnt !== 1) begin n_err++; $display("FAIL db_irq: got %0d want 1", irq_cnt); end
  endtask

  task automatic test_backpressure();
    do_reset();
    gnt_dly = 3; rv_dly = 5; c_addr = 5;
    scrub_en = 1;
    wait_rd(4);
    scrub_en = 0;
    wait_idle();
    n_cmp++; if (stab_err !== 0) begin n_err++; $display("FAIL bp_stable: got %0d unstable cycles want 0", stab_err); end
    n_cmp++; if (rd_q.size() !== 4) begin n_err++; $display("FAIL bp_nrd: got %0d want 4", rd_q.size()); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (rd_q.size() > i && rd_q[i] !== 4 + i) begin n_err++; $display("FAIL bp_addr%0d: got %0d want %0d", i, rd_q[i], 4 + i); end
    end
    n_cmp++; if (wr_q.size() !== 1 || (wr_q.size() > 0 && wr_q[0] !== 5)) begin n_err++; $display("FAIL bp_wr: got n=%0d want one write to 5", wr_q.size()); end
    n_cmp++; if (rd_cyc.size() > 2 && rd_cyc[1] - rd_cyc[0] !== 11) begin n_err++; $display("FAIL bp_gap_rd: got %0d want 11", rd_cyc[1] - rd_cyc[0]); end
    n_cmp++; if (rd_cyc.size() > 2 && rd_cyc[2] - rd_cyc[1] !== 15) begin n_err++; $display("FAIL bp_gap_wr: got %0d want 15", rd_cyc[2] - rd_cyc[1]); end
  endtask

  task automatic test_disable_mid();
    do_reset();
    addr_lo = 10'd8; addr_hi = 10'd12; c_addr = 9; rv_dly = 3;
    scrub_en = 1;
    wait_rd(2);
    scrub_en = 0;
    wait_idle();
    n_cmp++; if (rd_q.size() !== 2) begin n_err++; $display("FAIL dis_nrd: got %0d want 2", rd_q.size()); end
    n_cmp++; if (wr_q.size() !== 1 || (wr_q.size() > 0 && wr_q[0] !== 9)) begin n_err++; $display("FAIL dis_wb: got n=%0d want one write to 9", wr_q.size()); end
    n_cmp++; if (corr_cnt !== 16'd1) begin n_err++; $display("FAIL dis_cnt: got %0d want 1", corr_cnt); end
    scrub_en = 1;
    wait_rd(3);
    scrub_en = 0;
    n_cmp++; if (rd_q.size() > 2 && rd_q[2] !== 8) begin n_err++; $display("FAIL dis_restart: got %0d want 8", rd_q[2]); end
    wait_idle();
  endtask

  task automatic test_sat_clear();
    int irq0, w0, i;
    do_reset();
    addr_lo = 10'd0; addr_hi = 10'd7; corr_all = 1;
    scrub_en = 1;
    wait_wr(5);
    scrub_en = 0;
    wait_idle();
    n_cmp++; if (corr_cnt !== 16'd5) begin n_err++; $display("FAIL sat_wide: got %0d want 5", corr_cnt); end
    n_cmp++; if (corr_cnt2 !== 2'd3) begin n_err++; $display("FAIL sat_narrow: got %0d want 3", corr_cnt2); end
    // clear lands in the same cycle as a correctable read at addr 0
    irq0 = irq_cnt; w0 = wr_q.size(); clr_once = 1;
    scrub_en = 1;
    wait_wr(w0 + 1);
    scrub_en = 0;
    wait_idle();
    n_cmp++; if (corr_cnt !== '0 || corr_cnt2 !== '0) begin n_err++; $display("FAIL clr_prio: got %0d/%0d want 0/0", corr_cnt, corr_cnt2); end
    n_cmp++; if (last_err_addr !== 10'd0 || irq_cnt - irq0 !== 1) begin n_err++; $display("FAIL clr_log: got addr=%0d irqs=%0d want 0/1", last_err_addr, irq_cnt - irq0); end
    // async reset while a writeback is waiting for its grant
    gnt_dly = 20;
    scrub_en = 1;
    for (i = 0; i < 200 && !(mem_req === 1'b1 && mem_we === 1'b1); i++) begin @(negedge clk); #1; end
    n_cmp++; if (!(mem_req === 1'b1 && mem_we === 1'b1)) begin n_err++; $display("FAIL rst_wr_reach: got req=%b we=%b want 1/1", mem_req, mem_we); end
    #2 rst = 1;
    #1;
    n_cmp++; if ({mem_req, mem_we, busy} !== 3'b000) begin n_err++; $display("FAIL rst_async: got req/we/busy=%b want 000", {mem_req, mem_we, busy}); end
    n_cmp++; if (corr_cnt !== '0 || mem_addr !== '0) begin n_err++; $display("FAIL rst_async_st: got cnt=%0d addr=%0d want 0/0", corr_cnt, mem_addr); end
    scrub_en = 0;
    @(negedge clk);
    #1 rst = 0;
  endtask

  initial begin
    test_reset();
    test_clean_window();
    test_single_bit();
    test_double_bit();
    test_backpressure();
    test_disable_mid();
    test_sat_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
